// File: rtl/serial_adder.sv
// Digit-serial adder: {cout,sum} = a + b + cin, DIGIT bits per clock.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]       a_sr, b_sr, acc;
  logic [WIDTH-1:0]       acc_nxt;
  logic [WIDTH+DIGIT-1:0] cat;
  logic                   carry;
  logic [CW-1:0]          cnt, cnt_inc;
  logic [DIGIT-1:0]       dsum;
  logic                   dcarry;
  logic                   cmsb;
  logic                   last;

  // One DIGIT-wide ripple of full-adder cells; cmsb is the carry into its top bit.
  always_comb begin
    logic cc;
    cc   = carry;
    dsum = '0;
    cmsb = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) cmsb = cc;
      dsum[i] = a_sr[i] ^ b_sr[i] ^ cc;
      cc = (a_sr[i] & b_sr[i]) | (cc & (a_sr[i] ^ b_sr[i]));
    end
    dcarry = cc;
  end

  assign cat     = {dsum, acc};
  assign acc_nxt = cat[WIDTH+DIGIT-1:DIGIT];
  assign cnt_inc = cnt + CW'(1);
  assign last    = (cnt_inc == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> DIGIT;
      b_sr  <= b_sr >> DIGIT;
      acc   <= acc_nxt;
      carry <= dcarry;
      cnt   <= cnt_inc;
      if (last) begin
        sum  <= acc_nxt;
        cout <= dcarry;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk) begin
    if (rst)                      ovf <= 1'b0;
    else if (state == RUN && last) ovf <= dcarry ^ cmsb;
  end
`else
  logic unused_ovf;
  assign unused_ovf = cmsb;
`endif

endmodule
